// File: rtl/div_seq_ctrl.sv
// Multi-cycle RV32M divide sequencer (DIV/DIVU/REM/REMU) using restoring shift-subtract.
// Optional result cache of the last completed division is built when DIV_RESULT_CACHE_EN is defined.
module div_seq_ctrl #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int STEPS = XLEN / BITS_PER_CYCLE;
  localparam int CW    = $clog2(STEPS + 1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [XLEN:0]   rem_q;
  logic [XLEN:0]   dvsr_q;
  logic [XLEN-1:0] quo_q;
  logic            is_rem_q;
  logic            neg_quo_q;
  logic            neg_rem_q;

  logic            op_signed;
  logic            op_rem;
  logic            accept;
  logic            special;
  logic [XLEN-1:0] special_res;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic [XLEN:0]   step_rem;
  logic [XLEN-1:0] step_quo;
  logic [XLEN-1:0] fin_quo;
  logic [XLEN-1:0] fin_rem;
  logic [XLEN-1:0] calc_res;
  logic            last_step;
  logic            cache_hit;
  logic [XLEN-1:0] cache_res;

  assign op_signed = ~op[0];
  assign op_rem    = op[1];
  assign accept    = (state == IDLE) & start & ~flush;
  assign busy      = (state != IDLE);
  assign stall_req = accept | (state == CALC);
  assign last_step = (state == CALC) && (cnt == CW'(1));

  // Divide-by-zero and signed overflow are answered directly from the operands.
  always_comb begin
    special     = 1'b0;
    special_res = '0;
    if (rs2 == '0) begin
      special     = 1'b1;
      special_res = op_rem ? rs1 : '1;
    end else if (op_signed && rs1 == MIN_INT && rs2 == '1) begin
      special     = 1'b1;
      special_res = op_rem ? '0 : MIN_INT;
    end
  end

  assign abs_a = (op_signed && rs1[XLEN-1]) ? -rs1 : rs1;
  assign abs_b = (op_signed && rs2[XLEN-1]) ? -rs2 : rs2;

  // NOTE: blocking assignments chain the BITS_PER_CYCLE sub-steps combinationally within one cycle.
  always_comb begin
    step_rem = rem_q;
    step_quo = quo_q;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      step_rem = {step_rem[XLEN-1:0], step_quo[XLEN-1]};
      step_quo = {step_quo[XLEN-2:0], 1'b0};
      if (step_rem >= dvsr_q) begin
        step_rem    = step_rem - dvsr_q;
        step_quo[0] = 1'b1;
      end
    end
  end

  assign fin_quo  = neg_quo_q ? -step_quo : step_quo;
  assign fin_rem  = neg_rem_q ? -step_rem[XLEN-1:0] : step_rem[XLEN-1:0];
  assign calc_res = is_rem_q ? fin_rem : fin_quo;

`ifdef DIV_RESULT_CACHE_EN
  logic            cache_valid;
  logic [XLEN-1:0] cache_a;
  logic [XLEN-1:0] cache_b;
  logic            cache_signed;
  logic [XLEN-1:0] cache_quo;
  logic [XLEN-1:0] cache_rem;
  logic [XLEN-1:0] op_a_q;
  logic [XLEN-1:0] op_b_q;
  logic            op_signed_q;

  always_ff @(posedge clk) begin
    if (!reset_n || flush)
      cache_valid <= 1'b0;
    else if (last_step)
      cache_valid <= 1'b1;
  end

  // NOTE: only the valid bit is reset; the stored operands and results are qualified by it.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_a_q      <= rs1;
      op_b_q      <= rs2;
      op_signed_q <= op_signed;
    end
    if (last_step && !flush) begin
      cache_a      <= op_a_q;
      cache_b      <= op_b_q;
      cache_signed <= op_signed_q;
      cache_quo    <= fin_quo;
      cache_rem    <= fin_rem;
    end
  end

  assign cache_hit = cache_valid && (rs1 == cache_a) && (rs2 == cache_b) &&
                     (op_signed == cache_signed);
  assign cache_res = op_rem ? cache_rem : cache_quo;
`else
  assign cache_hit = 1'b0;
  assign cache_res = '0;
`endif

  // Control state and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              cnt <= CW'(STEPS);
              if (special) begin
                state  <= DONE;
                done   <= 1'b1;
                result <= special_res;
              end else if (cache_hit) begin
                state  <= DONE;
                done   <= 1'b1;
                result <= cache_res;
              end else begin
                state <= CALC;
              end
            end
          end
          CALC: begin
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
              state  <= DONE;
              done   <= 1'b1;
              result <= calc_res;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Datapath registers need no reset: they are fully loaded on every accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      rem_q     <= '0;
      quo_q     <= abs_a;
      dvsr_q    <= {1'b0, abs_b};
      is_rem_q  <= op_rem;
      neg_quo_q <= op_signed & (rs1[XLEN-1] ^ rs2[XLEN-1]);
      neg_rem_q <= op_signed & rs1[XLEN-1];
    end else if (state == CALC) begin
      rem_q <= step_rem;
      quo_q <= step_quo;
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: directed RV32M cases plus randomized ops against an
// arithmetic reference model; follows DIV_RESULT_CACHE_EN when it is defined.
module tb_div_seq_ctrl;

  localparam logic [31:0] MIN_INT = 32'h8000_0000;
  localparam int NORMAL_LAT = 33;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        flush;
  logic        busy;
  logic        stall_req;
  logic        done;
  logic [31:0] result;

  int vectors = 0;
  int errors  = 0;

  // Reference-model state: last visible result and the cache contents.
  logic [31:0] last_res;
  bit          c_valid;
  logic [31:0] c_a;
  logic [31:0] c_b;
  bit          c_signed;

  div_seq_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .op        (op),
    .rs1       (rs1),
    .rs2       (rs2),
    .flush     (flush),
    .busy      (busy),
    .stall_req (stall_req),
    .done      (done),
    .result    (result)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    return (b == 0) || (!o[0] && a == MIN_INT && b == 32'hFFFF_FFFF);
  endfunction

  // RISC-V M-extension semantics, computed with plain language arithmetic.
  function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    int signed sa;
    int signed sb;
    sa = a;
    sb = b;
    if (b == 0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == MIN_INT && b == 32'hFFFF_FFFF) return o[1] ? 32'h0 : MIN_INT;
    case (o)
      2'b00:   return sa / sb;
      2'b01:   return a / b;
      2'b10:   return sa % sb;
      default: return a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (is_special(o, a, b)) return 1;
`ifdef DIV_RESULT_CACHE_EN
    if (c_valid && c_a == a && c_b == b && c_signed == !o[0]) return 1;
`endif
    return NORMAL_LAT;
  endfunction

  // Issues one op starting in the cycle after the current negedge and follows it to done.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit hold_start);
    logic [31:0] exp_res;
    int          exp_lat;
    int          cyc;
    exp_res = ref_result(o, a, b);
    exp_lat = ref_latency(o, a, b);
    @(negedge clk);
    check({name, "_idle_busy"}, {31'b0, busy}, 32'd0);
    check({name, "_held_result"}, result, last_res);
    start = 1'b1;
    op    = o;
    rs1   = a;
    rs2   = b;
    #1;
    check({name, "_stall_accept"}, {31'b0, stall_req}, 32'd1);
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    rs1 = $urandom;
    rs2 = $urandom;
    op  = 2'($urandom_range(0, 3));
    cyc = 1;
    while (!done && cyc < 40) begin
      if (cyc == 2) check({name, "_stall_calc"}, {31'b0, stall_req}, 32'd1);
      @(negedge clk);
      cyc++;
    end
    check({name, "_latency"}, cyc, exp_lat);
    check({name, "_result"}, result, exp_res);
    check({name, "_stall_done"}, {31'b0, stall_req}, 32'd0);
    start = 1'b0;
    last_res = exp_res;
    if (!is_special(o, a, b)) begin
      c_valid  = 1'b1;
      c_a      = a;
      c_b      = b;
      c_signed = !o[0];
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [1:0]  ro;
    int          saw_done;

    reset_n  = 1'b0;
    start    = 1'b0;
    flush    = 1'b0;
    op       = 2'b00;
    rs1      = '0;
    rs2      = '0;
    last_res = '0;
    c_valid  = 1'b0;
    c_a      = '0;
    c_b      = '0;
    c_signed = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_stall", {31'b0, stall_req}, 32'd0);
    reset_n = 1'b1;

    run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 1'b0);
    run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("div_5_0", 2'b00, 32'd5, 32'd0, 1'b0);
    run_op("remu_5_0", 2'b11, 32'd5, 32'd0, 1'b0);
    run_op("div_ovf", 2'b00, MIN_INT, 32'hFFFF_FFFF, 1'b0);
    run_op("rem_ovf", 2'b10, MIN_INT, 32'hFFFF_FFFF, 1'b0);

    // start together with flush in IDLE is not accepted
    @(negedge clk);
    start = 1'b1;
    flush = 1'b1;
    op    = 2'b01;
    rs1   = 32'd50;
    rs2   = 32'd5;
    #1;
    check("flush_idle_stall", {31'b0, stall_req}, 32'd0);
    @(negedge clk);
    check("flush_idle_busy", {31'b0, busy}, 32'd0);
    start   = 1'b0;
    flush   = 1'b0;
    c_valid = 1'b0;

    // flush in cycle 10 of DIVU 100/7
    @(negedge clk);
    start = 1'b1;
    op    = 2'b01;
    rs1   = 32'd100;
    rs2   = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("flush_calc_busy_before", {31'b0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_calc_busy", {31'b0, busy}, 32'd0);
    check("flush_calc_done", {31'b0, done}, 32'd0);
    check("flush_calc_result", result, last_res);
    saw_done = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) saw_done++;
    end
    check("flush_no_done", saw_done, 0);
    c_valid = 1'b0;
    run_op("divu_9_3", 2'b01, 32'd9, 32'd3, 1'b0);

    // reset mid-CALC with start held high
    @(negedge clk);
    start = 1'b1;
    op    = 2'b01;
    rs1   = 32'd1000;
    rs2   = 32'd3;
    repeat (5) @(negedge clk);
    check("rst_calc_busy_before", {31'b0, busy}, 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_calc_busy", {31'b0, busy}, 32'd0);
    check("rst_calc_done", {31'b0, done}, 32'd0);
    check("rst_calc_result", result, 32'd0);
    reset_n  = 1'b1;
    start    = 1'b0;
    last_res = '0;
    c_valid  = 1'b0;

    // DIV then REM on the same operands: hits when the cache is built in
    run_op("div_100_7", 2'b00, 32'd100, 32'd7, 1'b1);
    run_op("rem_100_7", 2'b10, 32'd100, 32'd7, 1'b0);

    ra = $urandom;
    rb = $urandom;
    for (int n = 0; n < 30; n++) begin
      ro = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: begin ra = $urandom; rb = 32'd0; end
        1: begin ra = MIN_INT; rb = 32'hFFFF_FFFF; end
        2: ;
        3: begin ra = $urandom; rb = 32'($urandom_range(1, 15)); end
        4: begin ra = -32'($urandom_range(1, 1000)); rb = -32'($urandom_range(1, 20)); end
        default: begin ra = $urandom; rb = $urandom; end
      endcase
      run_op("rand", ro, ra, rb, 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    check("final_busy", {31'b0, busy}, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
